// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-domain consumer for the asynchronous FIFO. On an accepted start it
//   pulls burst_len words out of the FIFO one at a time via ren/rack, parks
//   them in a 2-entry skid buffer, and streams them out on a valid/ready port.
//   A running XOR checksum and word count are kept for the current burst.
//   If the FIFO fails to acknowledge within TIMEOUT cycles the burst aborts
//   with a sticky error; words already captured still drain.
//
// Ports
//   rclk, rrst_n           read clock, synchronous active-low reset
//   start, burst_len       burst request (sampled in IDLE only) and length
//   rempty, rack, rdata    FIFO empty flag, read acknowledge, read data
//   ren                    FIFO read enable, one pulse per word
//   out_data, out_valid    skid buffer head / non-empty
//   out_ready              downstream accept
//   busy, done, error      status: not idle, completion pulse, sticky timeout
//   rd_count, checksum     words captured / XOR of captured words this burst
module fifo_burst_reader #(
    parameter int DATASIZE = 8,
    parameter int BURSTW   = 8,
    parameter int TIMEOUT  = 8
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                start,
    input  logic [BURSTW-1:0]   burst_len,
    input  logic                rempty,
    input  logic                rack,
    input  logic [DATASIZE-1:0] rdata,
    output logic                ren,
    output logic [DATASIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [BURSTW-1:0]   rd_count,
    output logic [DATASIZE-1:0] checksum
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [BURSTW-1:0]   len_q;
    logic [TW-1:0]       tcnt;
    logic [DATASIZE-1:0] sbuf [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          occ;
    logic [1:0]          occ_next;

    logic push;
    logic pop;
    logic take_start;
    logic last_word;
    logic timeout;

    // Datapath strobes
    always_comb begin
        push       = (state == ST_WAIT) && rack;
        pop        = out_valid && out_ready;
        take_start = (state == ST_IDLE) && start;
        last_word  = (rd_count + BURSTW'(1)) == len_q;
        // tcnt counts WAIT cycles from 0, so TLAST marks the TIMEOUT-th one
        timeout    = (state == ST_WAIT) && !rack && (tcnt == TLAST);

        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (burst_len != '0) state_next = ST_ISSUE;
                    else                 state_next = ST_DONE;
                end
            end
            // Only request when the FIFO has data and there is room for the
            // word; this is what keeps a push from ever hitting a full buffer.
            ST_ISSUE: begin
                if (!rempty && (occ < 2'd2)) state_next = ST_REQ;
            end
            ST_REQ: state_next = ST_WAIT;
            ST_WAIT: begin
                if (rack)         state_next = last_word ? ST_DRAIN : ST_ISSUE;
                else if (timeout) state_next = ST_DRAIN;
            end
            // Look at post-pop occupancy so done follows the final pop by one cycle
            ST_DRAIN: begin
                if (occ_next == 2'd0) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) state <= ST_IDLE;
        else         state <= state_next;
    end

    // ren is a flop so it is a clean one-cycle pulse coinciding with REQ
    always_ff @(posedge rclk) begin
        if (!rrst_n) ren <= 1'b0;
        else         ren <= (state_next == ST_REQ);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            occ      <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            sbuf[0]  <= '0;
            sbuf[1]  <= '0;
            len_q    <= '0;
            tcnt     <= '0;
            rd_count <= '0;
            checksum <= '0;
            error    <= 1'b0;
        end else begin
            occ <= occ_next;

            if (push) begin
                sbuf[wr_ptr] <= rdata;
                wr_ptr       <= ~wr_ptr;
                rd_count     <= rd_count + BURSTW'(1);
                checksum     <= checksum ^ rdata;
            end

            if (pop) rd_ptr <= ~rd_ptr;

            // Counter is held at zero outside WAIT, so it restarts on every entry
            tcnt <= (state == ST_WAIT) ? tcnt + TW'(1) : '0;

            if (take_start) begin
                error <= 1'b0;
                if (burst_len != '0) begin
                    len_q    <= burst_len;
                    rd_count <= '0;
                    checksum <= '0;
                end
            end else if (timeout) begin
                error <= 1'b1;
            end
        end
    end

    assign out_data  = sbuf[rd_ptr];
    assign out_valid = (occ != 2'd0);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule
